dct_coeff_accum: RTL and testbench

- Sequential multiply-accumulate stage that consumes the cosine-term LUT for one fixed DCT frequency pair (k1=2, k2=3) and produces one 2-D DCT coefficient per 8x8 pixel block.
- Accepts 64 raster-ordered pixels over a valid/ready stream and drives the LUT index (n1=row, n2=column).
- Multiplies each pixel by the LUT's combinational 32-bit signed cos_term, accumulates, rounds away the LUT fixed-point scale, and emits the coefficient over a valid/ready output.

---
 rtl/dct_coeff_accum.sv | 135 +++++++++++++
 tb/tb_dct_coeff_accum.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/dct_coeff_accum.sv
// dct_coeff_accum: multiply-accumulate stage for one 2-D DCT coefficient (k1=2, k2=3).
// It takes one 8x8 block of 64 raster-ordered pixels, drives the external cosine-term LUT
// index and weights each pixel by the combinational LUT value. The accumulated sum is
// rounded to remove the LUT fixed-point scale, saturated, and emitted as one coefficient.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        synchronous active-low reset
//   pix_valid    pixel available
//   pix_ready    block accepts pixel (only while accumulating)
//   pix_data     unsigned pixel, raster order
//   lut_n1       LUT row index (idx[5:3])
//   lut_n2       LUT column index (idx[2:0])
//   lut_cos      signed cos term from the LUT, combinational from lut_n1/lut_n2
//   coeff_valid  coefficient available
//   coeff_ready  downstream accepts coefficient
//   coeff_data   signed rounded coefficient, holds its value after the handshake
//   busy         high whenever the block is not idle
//
// Build option: define DCT_LEVEL_SHIFT_EN to subtract 128 from each pixel (JPEG-style level
// shift) before the multiply. When it is undefined, pixels are used zero-extended.
module dct_coeff_accum #(
  parameter int unsigned PIXEL_W   = 8,
  parameter int unsigned COS_W     = 32,
  parameter int unsigned FRAC_BITS = 8,
  parameter int unsigned ACC_W     = 48,
  parameter int unsigned OUT_W     = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               pix_valid,
  output logic               pix_ready,
  input  logic [PIXEL_W-1:0] pix_data,
  output logic [2:0]         lut_n1,
  output logic [2:0]         lut_n2,
  input  logic [COS_W-1:0]   lut_cos,
  output logic               coeff_valid,
  input  logic               coeff_ready,
  output logic [OUT_W-1:0]   coeff_data,
  output logic               busy
);

  localparam int unsigned PROD_W = PIXEL_W + 1 + COS_W;

  typedef enum logic [1:0] {StIdle, StAccum, StRound, StOutput} state_e;

  state_e                   state_q, state_d;
  logic [5:0]               idx_q, idx_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic [OUT_W-1:0]         coeff_q, coeff_d;

  logic signed [PIXEL_W:0]  pix_s;
  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W:0]    rnd_sum;
  logic signed [ACC_W:0]    rnd;
  logic [ACC_W-OUT_W+1:0]   rnd_hi;
  logic [OUT_W-1:0]         rnd_sat;

`ifdef DCT_LEVEL_SHIFT_EN
  // pix - 2^(PIXEL_W-1): flipping the MSB gives the two's-complement value, then sign-extend.
  assign pix_s = {~pix_data[PIXEL_W-1], ~pix_data[PIXEL_W-1], pix_data[PIXEL_W-2:0]};
`else
  assign pix_s = {1'b0, pix_data};
`endif

  assign prod = PROD_W'(pix_s) * PROD_W'($signed(lut_cos));

  // Add half an LSB of the output scale, then floor-shift: round half up.
  assign rnd_sum = (ACC_W + 1)'(acc_q)
                 + $signed({{(ACC_W + 1 - FRAC_BITS){1'b0}}, 1'b1, {(FRAC_BITS - 1){1'b0}}});
  assign rnd     = rnd_sum >>> FRAC_BITS;

  // Value fits in OUT_W when every bit above the output sign bit matches it.
  assign rnd_hi  = rnd[ACC_W:OUT_W-1];
  always_comb begin
    rnd_sat = rnd[OUT_W-1:0];
    if (!((&rnd_hi) || !(|rnd_hi))) begin
      rnd_sat = rnd[ACC_W] ? {1'b1, {(OUT_W - 1){1'b0}}} : {1'b0, {(OUT_W - 1){1'b1}}};
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    acc_d       = acc_q;
    coeff_d     = coeff_q;
    pix_ready   = 1'b0;
    coeff_valid = 1'b0;
    unique case (state_q)
      StIdle: state_d = StAccum;
      StAccum: begin
        pix_ready = 1'b1;
        if (pix_valid) begin
          acc_d = acc_q + ACC_W'(prod);
          idx_d = idx_q + 6'd1;  // wraps 63 -> 0 on the last pixel
          if (idx_q == 6'd63) begin
            state_d = StRound;
          end
        end
      end
      StRound: begin
        coeff_d = rnd_sat;
        state_d = StOutput;
      end
      StOutput: begin
        coeff_valid = 1'b1;
        if (coeff_ready) begin
          acc_d   = '0;
          state_d = StAccum;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      idx_q   <= '0;
      acc_q   <= '0;
      coeff_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      acc_q   <= acc_d;
      coeff_q <= coeff_d;
    end
  end

  assign lut_n1     = idx_q[5:3];
  assign lut_n2     = idx_q[2:0];
  assign coeff_data = coeff_q;
  assign busy       = (state_q != StIdle);

endmodule

// File: tb/tb_dct_coeff_accum.sv
// tb_dct_coeff_accum: directed bench for dct_coeff_accum. It models the (k1=2, k2=3)
// cosine LUT as 256-scaled values truncated toward zero. The expected values are hand
// computed and come out the same whether or not the level-shift option is built in.
module tb_dct_coeff_accum;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               pix_valid;
  logic               pix_ready;
  logic [7:0]         pix_data;
  logic [2:0]         lut_n1;
  logic [2:0]         lut_n2;
  logic [31:0]        lut_cos;
  logic               coeff_valid;
  logic               coeff_ready;
  logic signed [31:0] coeff_data;
  logic               busy;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  dct_coeff_accum dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pix_valid  (pix_valid),
    .pix_ready  (pix_ready),
    .pix_data   (pix_data),
    .lut_n1     (lut_n1),
    .lut_n2     (lut_n2),
    .lut_cos    (lut_cos),
    .coeff_valid(coeff_valid),
    .coeff_ready(coeff_ready),
    .coeff_data (coeff_data),
    .busy       (busy)
  );

  // trunc(256 * cos((2n1+1)*2*pi/16) * cos((2n2+1)*3*pi/16))
  function automatic logic signed [31:0] cos_term(input logic [2:0] n1, input logic [2:0] n2);
    int   col;
    int   mag;
    logic row_a;
    logic neg;
    row_a = (n1 == 3'd0) || (n1 == 3'd3) || (n1 == 3'd4) || (n1 == 3'd7);
    case (n2)
      3'd0, 3'd7: col = 0;
      3'd1, 3'd6: col = 1;
      3'd2, 3'd5: col = 2;
      default:    col = 3;
    endcase
    if (row_a) begin
      case (col)
        0:       mag = 196;
        1:       mag = 46;
        2:       mag = 231;
        default: mag = 131;
      endcase
    end else begin
      case (col)
        0:       mag = 81;
        1:       mag = 19;
        2:       mag = 96;
        default: mag = 54;
      endcase
    end
    neg = (n1 >= 3'd2 && n1 <= 3'd5) ^
          (n2 == 3'd1 || n2 == 3'd2 || n2 == 3'd3 || n2 == 3'd7);
    return neg ? 32'(-mag) : 32'(mag);
  endfunction

  always_comb lut_cos = cos_term(lut_n1, lut_n2);

  // 0: flat 200, 1: impulse 255 at (0,0), 2: 0 at (0,0) else 128, 3: flat 128
  function automatic logic [7:0] pix_of(input int mode, input int i);
    case (mode)
      0:       return 8'd200;
      1:       return (i == 0) ? 8'd255 : 8'd0;
      2:       return (i == 0) ? 8'd0 : 8'd128;
      default: return 8'd128;
    endcase
  endfunction

  task automatic check(input string tag, input longint got, input longint exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Called and returns at a negedge; the last transfer happens on the posedge before return.
  task automatic send_pixels(input int mode, input int count, input bit gaps);
    for (int i = 0; i < count; i++) begin
      if (gaps) begin
        pix_valid = 1'b0;
        repeat ($urandom_range(0, 3)) @(negedge clk);
      end
      pix_valid = 1'b1;
      pix_data  = pix_of(mode, i);
      for (int t = 0; t < 20 && !pix_ready; t++) @(negedge clk);
      check("pix_ready", pix_ready, 1);
      check("lut_idx", {lut_n1, lut_n2}, i % 64);
      @(negedge clk);
    end
    pix_valid = 1'b0;
  endtask

  // Entered in ROUND (one negedge after the 64th transfer); returns in ACCUM idx 0.
  task automatic finish_block(input longint exp, input int stall, input bit poke);
    check("round_valid", coeff_valid, 0);
    check("round_busy", busy, 1);
    check("round_pix_ready", pix_ready, 0);
    check("idx_wrap", {lut_n1, lut_n2}, 0);
    coeff_ready = 1'b0;
    @(negedge clk);
    check("out_valid", coeff_valid, 1);
    check("out_data", coeff_data, exp);
    if (poke) begin
      pix_valid = 1'b1;
      pix_data  = 8'hff;
    end
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      check("stall_valid", coeff_valid, 1);
      check("stall_data", coeff_data, exp);
      check("stall_pix_ready", pix_ready, 0);
      check("stall_idx", {lut_n1, lut_n2}, 0);
    end
    pix_valid   = 1'b0;
    coeff_ready = 1'b1;
    @(negedge clk);
    coeff_ready = 1'b0;
    check("post_valid", coeff_valid, 0);
    check("post_pix_ready", pix_ready, 1);
    check("post_hold", coeff_data, exp);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n       = 1'b0;
    pix_valid   = 1'b0;
    pix_data    = '0;
    coeff_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_pix_ready", pix_ready, 0);
    check("rst_coeff_valid", coeff_valid, 0);
    check("rst_coeff_data", coeff_data, 0);
    check("rst_busy", busy, 0);
    check("rst_idx", {lut_n1, lut_n2}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    send_pixels(0, 64, 1'b0);  // flat: cos terms cancel
    finish_block(0, 0, 1'b0);
    send_pixels(1, 64, 1'b0);  // impulse: (49980 + 128) >>> 8
    finish_block(195, 0, 1'b0);
    send_pixels(2, 64, 1'b0);  // -25088 -> floor(-97.5)
    finish_block(-98, 0, 1'b0);
    send_pixels(3, 64, 1'b0);
    finish_block(0, 0, 1'b0);
    send_pixels(1, 64, 1'b1);  // gaps, then stalled output with pix_valid poked
    finish_block(195, 5, 1'b1);
    send_pixels(1, 64, 1'b0);  // back-to-back after the previous handshake
    finish_block(195, 0, 1'b0);

    send_pixels(1, 30, 1'b0);  // partial block, then reset
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("midrst_busy", busy, 0);
    check("midrst_pix_ready", pix_ready, 0);
    check("midrst_coeff_data", coeff_data, 0);
    check("midrst_idx", {lut_n1, lut_n2}, 0);
    send_pixels(1, 64, 1'b0);
    finish_block(195, 0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
